// File: rtl/approx_mul_arbiter.sv
// approx_mul_arbiter: round-robin front end for one shared 8x8 approximate multiplier.
// S1 holds the granted operand pair and drives the external core; S2 captures the
// core's product together with the owner's index and offers it on the response channel.
module approx_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_x,
  input  logic [8*NREQ-1:0]   req_y,
  output logic [7:0]          mul_x,
  output logic [7:0]          mul_y,
  input  logic [15:0]         mul_z,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [15:0]         rsp_z,
  output logic [IDW-1:0]      rsp_id,
  output logic [15:0]         txn_count
);

  localparam logic [IDW-1:0] PTR_INIT = IDW'(NREQ - 1);

  logic             r_s1Valid;
  logic [7:0]       r_s1X;
  logic [7:0]       r_s1Y;
  logic [IDW-1:0]   r_s1Id;
  logic             r_s2Valid;
  logic [15:0]      r_s2Z;
  logic [IDW-1:0]   r_s2Id;
  logic [15:0]      r_txnCount;
  logic [IDW-1:0]   r_ptr;

  logic             w_advance;
  logic             w_s1Free;
  logic             w_accept;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grantIdx;
  logic [7:0]       w_selX;
  logic [7:0]       w_selY;
  logic             w_found;

  // S2 may reload when it is empty or its result is being taken; S1 may reload
  // when it is empty or is moving into S2 this cycle.
  assign w_advance = !r_s2Valid || rsp_ready;
  assign w_s1Free  = !r_s1Valid || w_advance;

  // Circular priority search starting just after the last winner; also muxes
  // the winner's operands so S1 can load them without a variable-width index.
  always_comb begin
    w_grant    = '0;
    w_grantIdx = '0;
    w_selX     = '0;
    w_selY     = '0;
    w_found    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!w_found && req_valid[j] && (((int'(r_ptr) + k) % NREQ) == j)) begin
          w_found    = 1'b1;
          w_grant[j] = 1'b1;
          w_grantIdx = IDW'(j);
          w_selX     = req_x[8*j +: 8];
          w_selY     = req_y[8*j +: 8];
        end
      end
    end
  end

  assign req_ready = (w_s1Free && !rst) ? w_grant : '0;
  assign w_accept  = |req_ready;

  // Two-stage pipeline, pointer and completion counter; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid  <= 1'b0;
      r_s1X      <= '0;
      r_s1Y      <= '0;
      r_s1Id     <= '0;
      r_s2Valid  <= 1'b0;
      r_s2Z      <= '0;
      r_s2Id     <= '0;
      r_txnCount <= '0;
      r_ptr      <= PTR_INIT;
    end else begin
      if (w_accept) begin
        r_s1Valid <= 1'b1;
        r_s1X     <= w_selX;
        r_s1Y     <= w_selY;
        r_s1Id    <= w_grantIdx;
        r_ptr     <= w_grantIdx;
      end else if (w_advance) begin
        r_s1Valid <= 1'b0;
      end
      if (w_advance) begin
        r_s2Valid <= r_s1Valid;
        r_s2Z     <= mul_z;
        r_s2Id    <= r_s1Id;
      end
      if (r_s2Valid && rsp_ready) begin
        r_txnCount <= r_txnCount + 16'd1;
      end
    end
  end

  assign mul_x     = r_s1X;
  assign mul_y     = r_s1Y;
  assign rsp_valid = r_s2Valid;
  assign rsp_z     = r_s2Z;
  assign rsp_id    = r_s2Id;
  assign txn_count = r_txnCount;

  // Grant sanity: never more than one winner, and never an idle requester.
  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(req_ready));
      assert ((req_ready & ~req_valid) == '0);
    end
  end

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// tb_approx_mul_arbiter: directed scenarios plus a random phase, checked by a
// scoreboard fed from a round-robin / occupancy reference model.
module tb_approx_mul_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [8*NREQ-1:0] req_x = '0;
  logic [8*NREQ-1:0] req_y = '0;
  logic [7:0]      mul_x;
  logic [7:0]      mul_y;
  logic [15:0]     mul_z;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [15:0]     rsp_z;
  logic [IDW-1:0]  rsp_id;
  logic [15:0]     txn_count;
  logic            useApprox = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0]    z;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t        expQ[$];
  int          inflight   = 0;
  int          lastGrant  = NREQ - 1;
  logic [15:0] modelCount = '0;

  always #5 clk = ~clk;

  // Stand-in for the external core: exact product, or an approximate one that
  // drops the low nibble of the result.
  assign mul_z = useApprox ? ((16'(mul_x) * 16'(mul_y)) & 16'hFFF0)
                           : (16'(mul_x) * 16'(mul_y));

  approx_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_id(rsp_id), .txn_count(txn_count)
  );

  // Golden core behaviour computed with integer arithmetic.
  function automatic logic [15:0] coreGolden(logic [7:0] a, logic [7:0] b, bit approx);
    int p;
    p = int'(a) * int'(b);
    if (approx) p = p - (p % 16);
    return 16'(p);
  endfunction

  // Next winner in circular order after 'last', or -1 when nobody is asking.
  function automatic int rrPick(logic [NREQ-1:0] v, int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Raise one request and hold it until it is accepted; reports how many
  // cycles that took.
  task automatic applyStimulus(int idx, logic [7:0] x, logic [7:0] y, output int cycles);
    bit ok;
    ok = 1'b0;
    cycles = 0;
    req_x[8*idx +: 8] = x;
    req_y[8*idx +: 8] = y;
    req_valid[idx] = 1'b1;
    while (!ok && cycles < 50) begin
      @(negedge clk);
      ok = req_ready[idx];
      cycles++;
      nextCycle();
    end
    req_valid[idx] = 1'b0;
    if (!ok) checkOutput("send_timeout", 32'(cycles), 32'd0);
  endtask

  // Reference model and scoreboard: every sample point predicts the grant from
  // round-robin order and pipeline occupancy, queues the expected product on
  // accept and compares each response handshake against the queue head.
  always @(negedge clk) begin
    int  w;
    bit  expGrant;
    exp_t e;
    if (rst) begin
      expQ.delete();
      inflight   = 0;
      lastGrant  = NREQ - 1;
      modelCount = '0;
    end else begin
      expGrant = (|req_valid) && (inflight < 2 || rsp_ready);
      w = rrPick(req_valid, lastGrant);
      checkOutput("grant_present", 32'(req_ready != '0), 32'(expGrant));
      if (expGrant) checkOutput("grant_rr", 32'(req_ready), 32'(1 << w));
      checkOutput("txn_count", 32'(txn_count), 32'(modelCount));
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_z", 32'(rsp_z), 32'(e.z));
          checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
          inflight--;
          modelCount = modelCount + 16'd1;
        end
      end
      if (expGrant) begin
        e.z  = coreGolden(req_x[8*w +: 8], req_y[8*w +: 8], useApprox);
        e.id = IDW'(w);
        expQ.push_back(e);
        lastGrant = w;
        inflight++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cyc;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_mul_x", 32'(mul_x), 32'd0);
    checkOutput("reset_mul_y", 32'(mul_y), 32'd0);
    checkOutput("reset_rsp_z", 32'(rsp_z), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_txn_count", 32'(txn_count), 32'd0);
    nextCycle();

    // Single request from requester 2, two-cycle latency
    rsp_ready = 1'b1;
    applyStimulus(2, 8'h0F, 8'h03, cyc);
    checkOutput("single_accept_cycles", 32'(cyc), 32'd1);
    @(negedge clk);
    checkOutput("single_not_yet_valid", 32'(rsp_valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("single_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("single_rsp_z", 32'(rsp_z), 32'h002D);
    checkOutput("single_rsp_id", 32'(rsp_id), 32'd2);
    nextCycle();
    @(negedge clk);
    checkOutput("single_txn_count", 32'(txn_count), 32'd1);
    nextCycle();

    // Round robin with all requesters valid
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    req_x = {8'h14, 8'h13, 8'h12, 8'h11};
    req_y = {8'h24, 8'h23, 8'h22, 8'h21};
    req_valid = 4'hF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("rr_order", 32'(req_ready), 32'(1 << (i % 4)));
      nextCycle();
    end
    req_valid = '0;
    repeat (4) nextCycle();
    @(negedge clk);
    checkOutput("rr_txn_count", 32'(txn_count), 32'd12);
    nextCycle();

    // Backpressure: two pairs fill the pipeline, a third requester waits
    rsp_ready = 1'b0;
    req_x = {8'h00, 8'h09, 8'h05, 8'h12};
    req_y = {8'h00, 8'h09, 8'h07, 8'h34};
    req_valid = 4'b0011;
    @(negedge clk);
    checkOutput("bp_grant0", 32'(req_ready), 32'b0001);
    nextCycle();
    req_valid = 4'b0010;
    @(negedge clk);
    checkOutput("bp_grant1", 32'(req_ready), 32'b0010);
    nextCycle();
    req_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_full_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_hold_id", 32'(rsp_id), 32'd0);
      checkOutput("bp_hold_z", 32'(rsp_z), 32'h03A8);
      nextCycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_grant", 32'(req_ready), 32'b0100);
    checkOutput("bp_first_id", 32'(rsp_id), 32'd0);
    nextCycle();
    req_valid = '0;
    @(negedge clk);
    checkOutput("bp_second_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_second_id", 32'(rsp_id), 32'd1);
    checkOutput("bp_second_z", 32'(rsp_z), 32'h0023);
    repeat (3) nextCycle();

    // Approximate core attached: product passes through untouched
    useApprox = 1'b1;
    applyStimulus(1, 8'hFF, 8'hFF, cyc);
    @(negedge clk);
    nextCycle();
    @(negedge clk);
    checkOutput("approx_valid", 32'(rsp_valid), 32'd1);
    checkOutput("approx_z", 32'(rsp_z), 32'hFE00);
    checkOutput("approx_not_exact", 32'(rsp_z != 16'hFE01), 32'd1);
    repeat (2) nextCycle();
    useApprox = 1'b0;

    // Mid-operation reset with S1 and S2 both occupied
    rsp_ready = 1'b0;
    req_x = {8'h04, 8'h03, 8'h02, 8'h01};
    req_y = {8'h05, 8'h06, 8'h07, 8'h08};
    req_valid = 4'b0011;
    @(negedge clk);
    nextCycle();
    req_valid = 4'b0010;
    @(negedge clk);
    nextCycle();
    req_valid = '0;
    @(negedge clk);
    checkOutput("midrst_full_valid", 32'(rsp_valid), 32'd1);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_txn_count", 32'(txn_count), 32'd0);
    checkOutput("midrst_mul_x", 32'(mul_x), 32'd0);
    checkOutput("midrst_mul_y", 32'(mul_y), 32'd0);
    checkOutput("midrst_first_grant", 32'(req_ready), 32'b0001);
    nextCycle();
    req_valid = '0;
    repeat (4) nextCycle();

    // Counter wrap from 0xFFFF
    force dut.r_txnCount = 16'hFFFF;
    modelCount = 16'hFFFF;
    nextCycle();
    release dut.r_txnCount;
    applyStimulus(3, 8'h02, 8'h03, cyc);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("wrap_txn_count", 32'(txn_count), 32'd0);
    nextCycle();

    // Random traffic with random backpressure
    useApprox = 1'($urandom_range(0, 1));
    for (int i = 0; i < 400; i++) begin
      req_valid = NREQ'($urandom);
      req_x     = $urandom;
      req_y     = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      nextCycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && inflight != 0; i++) nextCycle();
    checkOutput("drain_inflight", 32'(inflight), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
